mult4_share_ctrl: RTL and testbench
===================================

# mult4_share_ctrl

Round-robin scheduler that time-shares one 4×4 multiplier between two requesters. Each requester uses a valid/ready handshake. The block registers the winning operands and drives them to the multiplier with a one-cycle start pulse. It waits a fixed, parameterised latency, captures the product and returns it on a single tagged response port with backpressure. It sits between the `tt_um_Mult4` top-level I/O decode and the multiplier datapath.

## Interface
- `W`, 4: operand width; product width is 2W.
- `LAT`, 2: multiplier latency in cycles, legal 1..15. The mul_start cycle is cycle 1, so product is valid in cycle LAT.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation.
- `req0_a`, `req0_b` input W: requester 0 operands.
- `req0_ready` output 1: requester 0 accepted on this edge when valid & ready.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `mul_a`, `mul_b` output W: registered operands to the multiplier.
- `mul_start` output 1: one-cycle start pulse.
- `mul_p` input 2W: multiplier product.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_id` output 1: requester index of the response.
- `rsp_p` output 2W: captured product.
- `op_count` output 8: completed responses, wraps 255→0.

## Operation
- **States:**
  - IDLE: arbitrate among requesters.
  - BUSY: multiplier running, counter `cnt` (4 bits) active.
  - DONE: response held for the consumer.
- **Arbitration:**
  - Performed only in IDLE.
  - If exactly one `reqN_valid` is high, that requester wins.
  - If both are high, the winner is the one indicated by the round-robin pointer `rr`.
  - `rr` resets to 0.
- **Ready:** `reqN_ready` is combinational and high only in IDLE, only for the winner. Both readies are 0 in BUSY and DONE and while `rst` is high.
- **IDLE → BUSY:**
  - Happens on a handshake (`valid & ready`).
  - The edge latches the winner's a/b into `mul_a`/`mul_b` and its index into `rsp_id`, and loads `cnt = LAT`.
- **BUSY:**
  - `mul_start = 1` in the first BUSY cycle only.
  - `cnt` decrements each edge.
  - On the edge where `cnt == 1`, `mul_p` is captured into `rsp_p` and the state moves to DONE.
- **DONE:**
  - `rsp_valid = 1`, and `rsp_id`/`rsp_p` are held stable.
  - On `rsp_ready` high: `rr` is set to `~rsp_id`, `op_count` increments, and the state returns to IDLE.
- **Held values:** `mul_a`/`mul_b` hold their last values outside BUSY.
- **Requester rules:**
  - A requester may drop valid without a handshake; this has no effect.
  - Operands are sampled only on the handshake edge.
- **Arithmetic:** the product is taken verbatim from `mul_p`, which is 2W bits wide; no truncation.
- **Reset (any state, including mid-BUSY or DONE):**
  - Returns to IDLE and drops any in-flight operation; no response is produced.
  - Output and register values: `mul_a`/`mul_b` = 0, `mul_start` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_p` = 0, `op_count` = 0, `rr` = 0, `cnt` = 0.

## Timing
- **Latency:** accept edge E0 → `rsp_valid` high after edge E_LAT.
- **Throughput:** minimum LAT+2 cycles per operation (IDLE, LAT×BUSY, DONE with `rsp_ready` = 1).
- **No new accept in DONE:** a new request can be accepted in the cycle after the DONE handshake, never the same cycle.
- **Simultaneous requests:** with `req0_valid = req1_valid = 1` continuously, grants alternate 0,1,0,1 starting from 0 after reset.
- **Backpressure:** `rsp_ready` low holds DONE indefinitely; all outputs remain stable.
- **Reset release:** first accept possible on the first edge after `rst` deasserts.

## Test plan
- **Single op:** W=4, LAT=2, reset, then req0 a=15, b=15 held valid.
  - `req0_ready` is high in the first cycle.
  - `mul_start` pulses once.
  - `rsp_valid` rises 2 edges after accept with `rsp_p` = 225, `rsp_id` = 0.
  - `op_count` = 1 after the `rsp_ready` handshake.
- **Contention:** both valid after reset, req0 (3×5), req1 (7×6), each held until ready.
  - Responses arrive in order: id 0 / 15, then id 1 / 42.
  - A third req0 (2×2) then wins against a still-valid req1, and the next response is id 0 / 4.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles in DONE with both requests valid.
  - `rsp_valid`/`rsp_p`/`rsp_id` stay stable and both readies stay 0.
  - Release `rsp_ready` → return to IDLE and the next grant goes to the other requester.
- **Reset mid-op:** assert `rst` during BUSY (LAT=4, cnt=2).
  - All outputs go to their reset values immediately.
  - No `rsp_valid` follows.
  - After release, a new req1 (9×9) yields 81, id 1.
- **LAT=1 with combinational multiplier model:** req1 0×9 and req0 15×1.
  - Responses are 0 and 15, each 1 edge after accept.
  - `mul_start` is a 1-cycle pulse per op.
- **Counter wrap:** 256 back-to-back ops.
  - `op_count` reads 255, then 0.
  - No lost or duplicated responses; ids alternate under continuous contention.

Source files
------------

// File: rtl/mult4_share_ctrl.sv
// mult4_share_ctrl
// Lets two requesters take turns on one W x W multiplier. Each requester
// uses a valid/ready handshake. The winner's operands are registered and
// sent to the multiplier with a one-cycle start pulse. After LAT cycles the
// product is captured and returned on one tagged response port, which the
// consumer can hold off with rsp_ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate; the winner's ready is high, and a handshake starts an op
// BUSY  | multiplier running; cnt counts down from LAT to the capture edge
// DONE  | response held on rsp_* until the consumer takes it
//
// LAT must be in 1..15 because the down-counter is 4 bits wide. The first
// BUSY cycle (mul_start high) is cycle 1, so mul_p is sampled at the end of
// cycle LAT.

module mult4_share_ctrl #(
    parameter int W   = 4,
    parameter int LAT = 2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,

    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    output logic             mul_start,
    input  logic [2*W-1:0]   mul_p,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_p,

    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic        rr_q;

    logic        win_any;
    logic        win_id;
    logic        accept;
    logic        cnt_tc;
    logic        rsp_take;

    // Pick the winner: a lone valid requester wins outright; if both are
    // valid, the round-robin pointer decides.
    always_comb begin
        win_any = req0_valid | req1_valid;
        win_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            win_id = rr_q;
        end else if (req1_valid) begin
            win_id = 1'b1;
        end
    end

    // Ready is offered only in IDLE and only to the winner. It is gated by
    // rst so that nothing can be accepted while reset is asserted.
    always_comb begin
        req0_ready = (state_q == IDLE) && !rst && win_any && !win_id;
        req1_ready = (state_q == IDLE) && !rst && win_id;
        accept     = req0_ready | req1_ready;
        cnt_tc     = (state_q == BUSY) && (cnt_q == 4'd1);
        rsp_take   = (state_q == DONE) && rsp_ready;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture and start pulse. mul_start is registered from the
    // accept edge, so it is high exactly in the first BUSY cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_id    <= 1'b0;
            mul_start <= 1'b0;
        end else begin
            mul_start <= accept;
            if (accept) begin
                mul_a  <= win_id ? req1_a : req0_a;
                mul_b  <= win_id ? req1_b : req0_b;
                rsp_id <= win_id;
            end
        end
    end

    // Latency down-counter: loaded with LAT on accept and counted down in
    // BUSY. The edge where it reads 1 is the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (accept) begin
            cnt_q <= 4'(LAT);
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Capture the full-width product on the terminal-count edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_p <= '0;
        end else if (cnt_tc) begin
            rsp_p <= mul_p;
        end
    end

    // When a response completes, point round-robin priority away from the
    // requester just served and bump the wrapping completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q     <= 1'b0;
            op_count <= 8'd0;
        end else if (rsp_take) begin
            rr_q     <= ~rsp_id;
            op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mult4_share_ctrl.sv
// Directed bench for mult4_share_ctrl. It builds three instances (LAT = 2, 4
// and 1), and each one has a multiplier model that returns the product only
// in cycle LAT of an operation and a poison value (0xEE) in every other cycle.

module tb_mult4_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst        [3];
    logic       r0v        [3];
    logic [3:0] r0a        [3];
    logic [3:0] r0b        [3];
    logic       r0rdy      [3];
    logic       r1v        [3];
    logic [3:0] r1a        [3];
    logic [3:0] r1b        [3];
    logic       r1rdy      [3];
    logic [3:0] mul_a      [3];
    logic [3:0] mul_b      [3];
    logic       mul_start  [3];
    logic [7:0] mul_p      [3];
    logic       rsp_valid  [3];
    logic       rsp_ready  [3];
    logic       rsp_id     [3];
    logic [7:0] rsp_p      [3];
    logic [7:0] op_count   [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 4 : 1;
        logic [3:0] k = 4'd0;
        logic [3:0] cyc;

        // k tracks the operation cycle number after the start cycle.
        always @(posedge clk) begin
            if (mul_start[g])
                k <= 4'd2;
            else if (k != 4'd0 && k != 4'd15)
                k <= 4'(k + 4'd1);
            else
                k <= 4'd0;
        end

        assign cyc = mul_start[g] ? 4'd1 : k;
        assign mul_p[g] = (cyc == 4'(L)) ? ({4'b0, mul_a[g]} * {4'b0, mul_b[g]}) : 8'hEE;

        mult4_share_ctrl #(.W(4), .LAT(L)) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0_valid (r0v[g]),
            .req0_a     (r0a[g]),
            .req0_b     (r0b[g]),
            .req0_ready (r0rdy[g]),
            .req1_valid (r1v[g]),
            .req1_a     (r1a[g]),
            .req1_b     (r1b[g]),
            .req1_ready (r1rdy[g]),
            .mul_a      (mul_a[g]),
            .mul_b      (mul_b[g]),
            .mul_start  (mul_start[g]),
            .mul_p      (mul_p[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_id     (rsp_id[g]),
            .rsp_p      (rsp_p[g]),
            .op_count   (op_count[g])
        );
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            r0v[i] = 1'b0; r0a[i] = 4'd0; r0b[i] = 4'd0;
            r1v[i] = 1'b0; r1a[i] = 4'd0; r1b[i] = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        tick;
        tick;

        // Single op, LAT=2
        r0v[0] = 1'b1; r0a[0] = 4'd15; r0b[0] = 4'd15;
        settle;
        check("rst_ready0", r0rdy[0], 0);
        check("rst_mul_a", mul_a[0], 0);
        check("rst_mul_start", mul_start[0], 0);
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_op_count", op_count[0], 0);
        rst[0] = 1'b0;
        settle;
        check("t1_ready0", r0rdy[0], 1);
        check("t1_ready1", r1rdy[0], 0);
        tick;
        check("t1_start", mul_start[0], 1);
        check("t1_mul_a", mul_a[0], 15);
        check("t1_mul_b", mul_b[0], 15);
        check("t1_busy_ready0", r0rdy[0], 0);
        tick;
        check("t1_start_off", mul_start[0], 0);
        check("t1_early_valid", rsp_valid[0], 0);
        tick;
        check("t1_rsp_valid", rsp_valid[0], 1);
        check("t1_rsp_p", rsp_p[0], 225);
        check("t1_rsp_id", rsp_id[0], 0);
        check("t1_done_ready0", r0rdy[0], 0);
        check("t1_done_start", mul_start[0], 0);
        rsp_ready[0] = 1'b1; r0v[0] = 1'b0;
        tick;
        check("t1_rsp_drop", rsp_valid[0], 0);
        check("t1_op_count", op_count[0], 1);

        // Contention after reset
        rst[0] = 1'b1;
        settle;
        check("t2_rst_op_count", op_count[0], 0);
        rst[0] = 1'b0;
        r0v[0] = 1'b1; r0a[0] = 4'd3; r0b[0] = 4'd5;
        r1v[0] = 1'b1; r1a[0] = 4'd7; r1b[0] = 4'd6;
        settle;
        check("t2_ready0_first", r0rdy[0], 1);
        check("t2_ready1_first", r1rdy[0], 0);
        tick;
        r0v[0] = 1'b0;
        check("t2_mul_a0", mul_a[0], 3);
        check("t2_mul_b0", mul_b[0], 5);
        tick;
        tick;
        check("t2_rsp0_valid", rsp_valid[0], 1);
        check("t2_rsp0_id", rsp_id[0], 0);
        check("t2_rsp0_p", rsp_p[0], 15);
        tick;
        r0v[0] = 1'b1; r0a[0] = 4'd2; r0b[0] = 4'd2;
        settle;
        check("t2_ready1_second", r1rdy[0], 1);
        check("t2_ready0_second", r0rdy[0], 0);
        tick;
        check("t2_mul_a1", mul_a[0], 7);
        check("t2_mul_b1", mul_b[0], 6);
        tick;
        tick;
        check("t2_rsp1_valid", rsp_valid[0], 1);
        check("t2_rsp1_id", rsp_id[0], 1);
        check("t2_rsp1_p", rsp_p[0], 42);
        tick;
        check("t2_ready0_third", r0rdy[0], 1);
        check("t2_ready1_third", r1rdy[0], 0);
        tick;
        r0v[0] = 1'b0;
        tick;
        tick;
        check("t2_rsp2_id", rsp_id[0], 0);
        check("t2_rsp2_p", rsp_p[0], 4);
        check("t2_op_count", op_count[0], 2);

        // Backpressure in DONE with both requesters valid
        rsp_ready[0] = 1'b0;
        r0v[0] = 1'b1; r0a[0] = 4'd1; r0b[0] = 4'd1;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t3_hold_valid", rsp_valid[0], 1);
            check("t3_hold_p", rsp_p[0], 4);
            check("t3_hold_id", rsp_id[0], 0);
            check("t3_hold_ready0", r0rdy[0], 0);
            check("t3_hold_ready1", r1rdy[0], 0);
        end
        rsp_ready[0] = 1'b1;
        tick;
        check("t3_release_valid", rsp_valid[0], 0);
        check("t3_release_ready1", r1rdy[0], 1);
        check("t3_release_ready0", r0rdy[0], 0);
        check("t3_release_count", op_count[0], 3);
        tick;
        r0v[0] = 1'b0; r1v[0] = 1'b0;
        check("t3_next_mul_a", mul_a[0], 7);
        tick;
        tick;
        check("t3_next_id", rsp_id[0], 1);
        check("t3_next_p", rsp_p[0], 42);
        tick;
        check("t3_final_count", op_count[0], 4);

        // Reset in the middle of BUSY, LAT=4
        rst[1] = 1'b0; rsp_ready[1] = 1'b1;
        r0v[1] = 1'b1; r0a[1] = 4'd3; r0b[1] = 4'd3;
        settle;
        tick;
        r0v[1] = 1'b0;
        tick;
        tick;
        tick;
        check("t4_lat_boundary", rsp_valid[1], 0);
        tick;
        check("t4_pre_valid", rsp_valid[1], 1);
        check("t4_pre_p", rsp_p[1], 9);
        tick;
        check("t4_pre_count", op_count[1], 1);
        r1v[1] = 1'b1; r1a[1] = 4'd6; r1b[1] = 4'd7;
        settle;
        tick;
        r1v[1] = 1'b0;
        check("t4_inflight_id", rsp_id[1], 1);
        check("t4_inflight_a", mul_a[1], 6);
        tick;
        tick;
        rst[1] = 1'b1;
        settle;
        check("t4_rst_mul_a", mul_a[1], 0);
        check("t4_rst_mul_b", mul_b[1], 0);
        check("t4_rst_start", mul_start[1], 0);
        check("t4_rst_valid", rsp_valid[1], 0);
        check("t4_rst_id", rsp_id[1], 0);
        check("t4_rst_p", rsp_p[1], 0);
        check("t4_rst_count", op_count[1], 0);
        tick;
        rst[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t4_no_rsp", rsp_valid[1], 0);
        end
        r0v[1] = 1'b1; r0a[1] = 4'd1; r0b[1] = 4'd1;
        r1v[1] = 1'b1; r1a[1] = 4'd9; r1b[1] = 4'd9;
        settle;
        check("t4_rr_reset", r0rdy[1], 1);
        r0v[1] = 1'b0;
        settle;
        check("t4_ready1", r1rdy[1], 1);
        tick;
        r1v[1] = 1'b0;
        tick;
        tick;
        tick;
        check("t4_post_early", rsp_valid[1], 0);
        tick;
        check("t4_post_valid", rsp_valid[1], 1);
        check("t4_post_p", rsp_p[1], 81);
        check("t4_post_id", rsp_id[1], 1);
        tick;

        // LAT=1 with the product available in the start cycle
        rst[2] = 1'b0; rsp_ready[2] = 1'b1;
        r1v[2] = 1'b1; r1a[2] = 4'd0; r1b[2] = 4'd9;
        settle;
        check("t5_ready1", r1rdy[2], 1);
        tick;
        r1v[2] = 1'b0;
        check("t5_start_a", mul_start[2], 1);
        check("t5_mul_b", mul_b[2], 9);
        check("t5_no_valid", rsp_valid[2], 0);
        tick;
        check("t5_valid_a", rsp_valid[2], 1);
        check("t5_p_a", rsp_p[2], 0);
        check("t5_id_a", rsp_id[2], 1);
        check("t5_start_off_a", mul_start[2], 0);
        tick;
        r0v[2] = 1'b1; r0a[2] = 4'd15; r0b[2] = 4'd1;
        settle;
        check("t5_ready0", r0rdy[2], 1);
        tick;
        r0v[2] = 1'b0;
        check("t5_start_b", mul_start[2], 1);
        tick;
        check("t5_valid_b", rsp_valid[2], 1);
        check("t5_p_b", rsp_p[2], 15);
        check("t5_id_b", rsp_id[2], 0);
        check("t5_start_off_b", mul_start[2], 0);
        tick;
        check("t5_count", op_count[2], 2);

        // 256 back-to-back ops under continuous contention, LAT=1
        rst[2] = 1'b1;
        settle;
        rst[2] = 1'b0;
        r0v[2] = 1'b1; r0a[2] = 4'd3; r0b[2] = 4'd4;
        r1v[2] = 1'b1; r1a[2] = 4'd5; r1b[2] = 4'd6;
        for (int i = 0; i < 256; i++) begin
            int w;
            w = 0;
            while (!rsp_valid[2] && w < 8) begin
                tick;
                w++;
            end
            check("wrap_cycles", w, 2);
            check("wrap_id", rsp_id[2], i % 2);
            check("wrap_p", rsp_p[2], (i % 2 == 1) ? 30 : 12);
            check("wrap_count", op_count[2], i % 256);
            tick;
        end
        check("wrap_final", op_count[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
